// File: rtl/is_uart_tx_arbiter_pkg.sv
// rtl/is_uart_tx_arbiter_pkg.sv - shared types and defaults for the UART controller
package is_pkg_uart_controller;

   localparam int DATA_W_DEF      = 8;
   localparam int TIMEOUT_CYC_DEF = 65535;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT
   } arb_state_t;

   // Next index in a ring of n entries.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/is_uart_tx_arbiter_rr_picker.sv
// rtl/is_uart_tx_arbiter_rr_picker.sv - combinational round-robin select starting at ptr_i
module is_rr_picker #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] sel_o,
   output logic [IDX_W-1:0] idx_o
);

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      sel_o = '0;
      idx_o = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_i) + k) % N_REQ]) begin
            sel_o = '0;
            sel_o[(int'(ptr_i) + k) % N_REQ] = 1'b1;
            idx_o = IDX_W'((int'(ptr_i) + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/is_uart_tx_arbiter.sv
// rtl/is_uart_tx_arbiter.sv - round-robin, packet-locked arbiter in front of the UART TX FSM
module is_uart_tx_arbiter
   import is_pkg_uart_controller::*;
#(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_REQ-1:0]        req_valid_i,
   input  logic [N_REQ*DATA_W-1:0] req_data_i,
   input  logic [N_REQ-1:0]        req_last_i,
   output logic [N_REQ-1:0]        req_ready_o,
   output logic [N_REQ-1:0]        grant_o,
   output logic                    tx_req_o,
   output logic [DATA_W-1:0]       tx_data_o,
   input  logic                    tx_done_i,
   output logic                    busy_o,
   output logic                    timeout_o
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   arb_state_t        state_q;
   logic [IDX_W-1:0]  rr_ptr_q;
   logic [IDX_W-1:0]  owner_q;
   logic              lock_q;
   logic              last_q;
   logic [N_REQ-1:0]  grant_q;
   logic [DATA_W-1:0] tx_data_q;
   logic              done_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [N_REQ-1:0]  pick_req;
   logic [N_REQ-1:0]  pick_sel;
   logic [IDX_W-1:0]  pick_idx;
   logic              accept;
   logic              done_evt;
   logic              wd_expire;
   logic [IDX_W-1:0]  rr_ptr_d;

   // While locked, only the owner (whose bit grant_q still holds) may compete.
   assign pick_req = lock_q ? (req_valid_i & grant_q) : req_valid_i;

   is_rr_picker #(
      .N_REQ (N_REQ)
   ) u_picker (
      .req_i (pick_req),
      .ptr_i (rr_ptr_q),
      .sel_o (pick_sel),
      .idx_o (pick_idx)
   );

   assign req_ready_o = (state_q == ARB_IDLE) ? pick_sel : '0;
   assign accept      = (state_q == ARB_IDLE) && (|pick_sel);
   assign done_evt    = tx_done_i & ~done_q;
   assign wd_expire   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
   assign rr_ptr_d    = IDX_W'(wrap_inc(int'(owner_q), N_REQ));

   assign tx_req_o  = (state_q == ARB_ISSUE);
   assign timeout_o = (state_q == ARB_WAIT) && !done_evt && wd_expire;
   assign busy_o    = (state_q != ARB_IDLE);
   assign grant_o   = grant_q;
   assign tx_data_o = tx_data_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= ARB_IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         lock_q    <= 1'b0;
         last_q    <= 1'b0;
         grant_q   <= '0;
         tx_data_q <= '0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         done_q <= tx_done_i;
         case (state_q)
            ARB_IDLE: begin
               if (accept) begin
                  tx_data_q <= req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
                  grant_q   <= pick_sel;
                  owner_q   <= pick_idx;
                  last_q    <= req_last_i[pick_idx];
                  state_q   <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               cnt_q   <= '0;
               state_q <= ARB_WAIT;
            end
            ARB_WAIT: begin
               if (done_evt) begin
                  lock_q <= ~last_q;
                  if (last_q) begin
                     rr_ptr_q <= rr_ptr_d;
                     grant_q  <= '0;
                  end
                  state_q <= ARB_IDLE;
               end else if (wd_expire) begin
                  lock_q   <= 1'b0;
                  rr_ptr_q <= rr_ptr_d;
                  grant_q  <= '0;
                  state_q  <= ARB_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_is_uart_tx_arbiter.sv
// tb/tb_is_uart_tx_arbiter.sv - randomized bench for is_uart_tx_arbiter against a transaction-level model
module tb_is_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int TMO = 16;
   localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [N-1:0]    req_valid_i;
   logic [N*DW-1:0] req_data_i;
   logic [N-1:0]    req_last_i;
   logic [N-1:0]    req_ready_o;
   logic [N-1:0]    grant_o;
   logic            tx_req_o;
   logic [DW-1:0]   tx_data_o;
   logic            tx_done_i;
   logic            busy_o;
   logic            timeout_o;

   is_uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .req_ready_o (req_ready_o),
      .grant_o     (grant_o),
      .tx_req_o    (tx_req_o),
      .tx_data_o   (tx_data_o),
      .tx_done_i   (tx_done_i),
      .busy_o      (busy_o),
      .timeout_o   (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_err    = 0;

   // Per-requester byte streams; they feed the DUT and the model alike.
   logic [7:0] q_data [N][$];
   bit         q_last [N][$];
   int         acc_q [$];

   int         ph = P_IDLE;
   int         m_ptr = 0, m_owner = 0;
   bit         m_lock = 0, m_last = 0;
   logic [N-1:0] m_grant = '0;
   logic [7:0] exp_byte = 8'h00;
   bit         prev_done = 0;
   int         cyc = 0, strobe_cyc = 0, acc_cyc = 0, to_cyc = 0;
   int         n_strobe = 0, n_acc = 0, n_to = 0;
   bit         tx_auto = 1, tx_man_val = 0, gaps = 0;
   int         d_cnt = 0;
   logic [7:0] strobe_data = 8'h00;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit q_nonempty();
      for (int i = 0; i < N; i++) if (q_data[i].size() > 0) return 1;
      return 0;
   endfunction

   task automatic push_pkt(input int r, input int len);
      for (int b = 0; b < len; b++) begin
         q_data[r].push_back(8'($urandom_range(0, 255)));
         q_last[r].push_back(b == len - 1);
      end
   endtask

   task automatic step();
      logic [N-1:0] v;
      logic [N-1:0] er;
      int  sel;
      bit  rise, eto;
      @(negedge clk_i);
      cyc++;
      for (int i = 0; i < N; i++) begin
         v[i] = (q_data[i].size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
         req_data_i[i*DW +: DW] = (q_data[i].size() > 0) ? q_data[i][0] : 8'h00;
         req_last_i[i] = (q_last[i].size() > 0) ? q_last[i][0] : 1'b0;
      end
      req_valid_i = v;
      if (tx_auto) begin
         tx_done_i = (d_cnt == 1);
         if (d_cnt > 0) d_cnt--;
      end else begin
         tx_done_i = tx_man_val;
      end
      #1;
      er  = '0;
      sel = -1;
      if (ph == P_IDLE) begin
         if (m_lock) begin
            if (v[m_owner]) sel = m_owner;
         end else begin
            for (int k = 0; k < N; k++)
               if (sel < 0 && v[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
         end
         if (sel >= 0) er[sel] = 1'b1;
      end
      rise = tx_done_i && !prev_done;
      eto  = (ph == P_WAIT) && !rise && (cyc - strobe_cyc == TMO);
      check("ready", 32'(req_ready_o), 32'(er));
      check("tx_req", 32'(tx_req_o), 32'(ph == P_ISSUE));
      check("grant", 32'(grant_o), 32'(m_grant));
      check("busy", 32'(busy_o), 32'(ph != P_IDLE));
      check("timeout", 32'(timeout_o), 32'(eto));
      if (ph != P_IDLE) check("tx_data", 32'(tx_data_o), 32'(exp_byte));
      prev_done = tx_done_i;
      case (ph)
         P_IDLE: if (sel >= 0) begin
            exp_byte = q_data[sel].pop_front();
            m_last   = q_last[sel].pop_front();
            m_owner  = sel;
            m_grant  = '0;
            m_grant[sel] = 1'b1;
            acc_q.push_back(sel);
            acc_cyc = cyc;
            n_acc++;
            ph = P_ISSUE;
         end
         P_ISSUE: begin
            strobe_cyc  = cyc;
            strobe_data = tx_data_o;
            n_strobe++;
            if (tx_auto) d_cnt = $urandom_range(1, 6);
            ph = P_WAIT;
         end
         default: begin
            if (rise) begin
               m_lock = !m_last;
               if (m_last) begin
                  m_ptr   = (m_owner + 1) % N;
                  m_grant = '0;
               end
               ph = P_IDLE;
            end else if (eto) begin
               n_to++;
               to_cyc  = cyc;
               m_lock  = 0;
               m_ptr   = (m_owner + 1) % N;
               m_grant = '0;
               ph = P_IDLE;
            end
         end
      endcase
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((ph != P_IDLE || q_nonempty()) && n < max_cyc) begin
         step();
         n++;
      end
      check("drain_bound", 32'(n < max_cyc), 32'd1);
   endtask

   task automatic check_order(input string tag, input int exp [5]);
      check({tag, "_cnt"}, 32'(acc_q.size() >= 5), 32'd1);
      for (int i = 0; i < 5; i++) check(tag, 32'(acc_q[i]), 32'(exp[i]));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"}, 32'(grant_o), 32'd0);
      check({tag, "_txreq"}, 32'(tx_req_o), 32'd0);
      check({tag, "_txdata"}, 32'(tx_data_o), 32'd0);
      check({tag, "_busy"}, 32'(busy_o), 32'd0);
      check({tag, "_tmo"}, 32'(timeout_o), 32'd0);
      check({tag, "_ready"}, 32'(req_ready_o), 32'd0);
   endtask

   initial begin
      int n;
      rst_i = 1'b0;
      req_valid_i = '0;
      req_data_i = '0;
      req_last_i = '0;
      tx_done_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check_reset_outputs("rst");
      rst_i = 1'b1;

      // Fairness from rr_ptr=0, every byte last
      for (int r = 0; r < N; r++) begin push_pkt(r, 1); push_pkt(r, 1); end
      drain(400);
      check_order("fair", '{0, 1, 2, 3, 0});
      check("fair_strobes", 32'(n_strobe), 32'd8);

      // Single byte on requester 2
      acc_q.delete();
      q_data[2].push_back(8'hA5);
      q_last[2].push_back(1'b1);
      drain(100);
      check("single_idx", 32'(acc_q.size() == 1 && acc_q[0] == 2), 32'd1);
      check("single_data", 32'(strobe_data), 32'hA5);
      check("single_lat", 32'(strobe_cyc - acc_cyc), 32'd1);

      // Requester 0 moves rr_ptr to 1, then packet lock on requester 1
      push_pkt(0, 1);
      drain(100);
      acc_q.delete();
      push_pkt(1, 3);
      push_pkt(0, 1);
      push_pkt(3, 1);
      drain(200);
      check_order("lock", '{1, 1, 1, 3, 0});

      // Stale done level held through the strobe
      tx_auto = 0;
      tx_man_val = 1;
      push_pkt(0, 1);
      n = 0;
      while (ph != P_WAIT && n < 20) begin step(); n++; end
      check("stale_reach", 32'(ph == P_WAIT), 32'd1);
      repeat (5) step();
      check("stale_busy", 32'(busy_o), 32'd1);
      tx_man_val = 0;
      step();
      tx_man_val = 1;
      step();
      step();
      check("stale_done", 32'(busy_o), 32'd0);
      tx_man_val = 0;

      // Watchdog: requester 1 hangs on its first byte, 3 served next
      acc_q.delete();
      push_pkt(1, 2);
      push_pkt(3, 1);
      n = 0;
      while (n_to == 0 && n < 60) begin step(); n++; end
      check("tmo_seen", 32'(n_to), 32'd1);
      check("tmo_delay", 32'(to_cyc - strobe_cyc), 32'(TMO));
      tx_auto = 1;
      drain(200);
      check("tmo_n", 32'(acc_q.size()), 32'd3);
      check("tmo_next", 32'(acc_q[1]), 32'd3);
      check("tmo_last", 32'(acc_q[2]), 32'd1);

      // Randomized traffic with valid gaps
      gaps = 1;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 7) == 0) push_pkt($urandom_range(0, N - 1), $urandom_range(1, 4));
         step();
      end
      drain(3000);
      gaps = 0;
      check("strobes_eq_acc", 32'(n_strobe), 32'(n_acc));
      check("tmo_total", 32'(n_to), 32'd1);

      // Async reset while waiting for completion
      tx_auto = 0;
      tx_man_val = 0;
      push_pkt(2, 1);
      n = 0;
      while (ph != P_WAIT && n < 20) begin step(); n++; end
      step();
      check("rstw_busy", 32'(busy_o), 32'd1);
      @(posedge clk_i);
      #2;
      rst_i = 1'b0;
      #1;
      check_reset_outputs("rstw");
      ph = P_IDLE; m_ptr = 0; m_lock = 0; m_grant = '0; prev_done = 0;
      @(negedge clk_i);
      rst_i = 1'b1;
      tx_auto = 1;
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
